// File: rtl/piso_serializer.sv
// piso_serializer: W-bit valid/ready words in, one serial bit per clock out.
// Holding register lets back-to-back words stream with no idle bit.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   din, din_valid    parallel word and its valid strobe
//   din_ready         combinational: holding register free, not in reset
//   x, x_valid        registered serial bit and its qualifier
//   busy              registered: shifting or holding register full
//
// Build option: PISO_LSB_FIRST_EN emits din[0] first (default MSB first).
module piso_serializer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  output logic         x,
  output logic         x_valid,
  output logic         busy
);

  localparam int CW = $clog2(W);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t        state;
  logic [W-1:0]  sreg;
  logic [W-1:0]  hreg;
  logic [CW-1:0] cnt;
  logic          hvalid;

  logic          accept;
  logic          last;
  logic          load;
  logic          shift_nxt;
  logic          hvalid_nxt;
  logic          hfirst;
  logic          snext;
  logic [W-1:0]  sshift;

  assign din_ready = ~hvalid & ~rst;
  assign accept    = din_valid & din_ready;

  // last: the final bit of the current word is on x now
  assign last = (state == SHIFT) && (cnt == CW'(W - 1));
  assign load = hvalid & ((state == IDLE) | last);

  // accept needs hvalid==0 and load needs hvalid==1, so never both
  assign shift_nxt  = load | ((state == SHIFT) & ~last);
  assign hvalid_nxt = accept | (hvalid & ~load);

  // x is registered, so the first bit is taken straight from hreg
  // on the load edge and later bits one position ahead of sreg's end
`ifdef PISO_LSB_FIRST_EN
  assign hfirst = hreg[0];
  assign snext  = sreg[1];
  assign sshift = {1'b0, sreg[W-1:1]};
`else
  assign hfirst = hreg[W-1];
  assign snext  = sreg[W-2];
  assign sshift = {sreg[W-2:0], 1'b0};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sreg    <= '0;
      hreg    <= '0;
      cnt     <= '0;
      hvalid  <= 1'b0;
      x       <= 1'b0;
      x_valid <= 1'b0;
      busy    <= 1'b0;
    end else begin
      busy   <= shift_nxt | hvalid_nxt;
      hvalid <= hvalid_nxt;
      if (accept) begin
        hreg <= din;
      end
      case (state)
        IDLE: begin
          if (hvalid) begin
            sreg    <= hreg;
            cnt     <= '0;
            x       <= hfirst;
            x_valid <= 1'b1;
            state   <= SHIFT;
          end else begin
            x       <= 1'b0;
            x_valid <= 1'b0;
          end
        end
        SHIFT: begin
          if (last) begin
            if (hvalid) begin
              sreg    <= hreg;
              cnt     <= '0;
              x       <= hfirst;
              x_valid <= 1'b1;
            end else begin
              sreg    <= '0;
              cnt     <= '0;
              x       <= 1'b0;
              x_valid <= 1'b0;
              state   <= IDLE;
            end
          end else begin
            sreg <= sshift;
            cnt  <= cnt + 1'b1;
            x    <= snext;
          end
        end
        default: begin
          state   <= IDLE;
          x       <= 1'b0;
          x_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: scoreboard bench for piso_serializer.
// Accepted words push expected bits; x_valid cycles pop and compare.
module tb_piso_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din;
  logic         din_valid;
  logic         din_ready;
  logic         x;
  logic         x_valid;
  logic         busy;

  int total = 0;
  int bad   = 0;

  bit          exp_q[$];
  logic [31:0] cap;
  int          run;
  int          last_run;
  int          runs_done;
  int          xv_count;
  bit          mon_en;

  piso_serializer #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .x         (x),
    .x_valid   (x_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void push_word(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) begin
`ifdef PISO_LSB_FIRST_EN
      exp_q.push_back(w[i]);
`else
      exp_q.push_back(w[W-1-i]);
`endif
    end
  endfunction

  // inputs change only at posedge+1, so values here are the ones
  // the DUT samples at the next rising edge
  always @(negedge clk) begin
    if (mon_en) begin
      if (din_valid && din_ready) push_word(din);
      if (x_valid) begin
        if (exp_q.size() == 0) chk("extra_bit", 1, 0);
        else chk("xbit", {31'd0, x}, {31'd0, exp_q.pop_front()});
        cap = {cap[30:0], x};
        run++;
        xv_count++;
      end else begin
        chk("x_idle", {31'd0, x}, 0);
        if (run != 0) begin
          last_run = run;
          runs_done++;
        end
        run = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] w);
    int n;
    n = 0;
    din       = w;
    din_valid = 1'b1;
    while (!din_ready && n < 100) begin
      step();
      n++;
    end
    chk("send_timeout", {31'd0, n < 100}, 1);
    step();
    chk("rdy_full", {31'd0, din_ready}, 0);
    chk("busy_full", {31'd0, busy}, 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    din_valid = 1'b0;
    while (busy && n < 300) begin
      step();
      n++;
    end
    chk("idle_timeout", {31'd0, n < 300}, 1);
    step();
    step();
    chk("q_empty", exp_q.size(), 0);
    chk("idle_busy", {31'd0, busy}, 0);
    chk("idle_xv", {31'd0, x_valid}, 0);
  endtask

  initial begin
    int r0;
    int xv0;
    mon_en    = 1'b0;
    cap       = '0;
    run       = 0;
    last_run  = 0;
    runs_done = 0;
    xv_count  = 0;
    rst       = 1'b1;
    din_valid = 1'b1;
    din       = '1;

    repeat (2) begin
      @(negedge clk);
      chk("rst_x", {31'd0, x}, 0);
      chk("rst_xv", {31'd0, x_valid}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_rdy", {31'd0, din_ready}, 0);
    end
    rst       = 1'b0;
    din_valid = 1'b0;
    #1;
    chk("rdy_after_rst", {31'd0, din_ready}, 1);
    mon_en = 1'b1;
    step();
    chk("no_word_in_rst", {31'd0, busy}, 0);

    // single word: bits 1,0,1,0,0,0,0,0 in either build
    cap = '0;
    r0  = runs_done;
`ifdef PISO_LSB_FIRST_EN
    send(8'h05);
`else
    send(8'hA0);
`endif
    wait_idle();
    chk("single_run", last_run, 8);
    chk("single_cnt", runs_done - r0, 1);
    chk("single_bits", cap[7:0], 8'hA0);

    // back-to-back; these words are bit palindromes, so the
    // captured stream matches in both builds
    cap = '0;
    r0  = runs_done;
    send(8'hA5);
    send(8'h3C);
    send(8'hFF);
    wait_idle();
    chk("b2b_run", last_run, 24);
    chk("b2b_cnt", runs_done - r0, 1);
    chk("b2b_bits", cap[23:0], 24'hA53CFF);

    // next word presented while hreg is moving into sreg
    cap = '0;
    r0  = runs_done;
    send(8'h81);
    send(8'h42);
    wait_idle();
    chk("sim_run", last_run, 16);
    chk("sim_cnt", runs_done - r0, 1);
    chk("sim_bits", cap[15:0], 16'h8142);

    // mid-word reset while bit 3 of A5 is on x, 3C held
    send(8'hA5);
    send(8'h3C);
    din_valid = 1'b0;
    step();
    step();
    chk("mid_xv", {31'd0, x_valid}, 1);
    chk("mid_busy", {31'd0, busy}, 1);
    rst = 1'b1;
    #1;
    chk("mid_rdy_rst", {31'd0, din_ready}, 0);
    step();
    rst = 1'b0;
    exp_q.delete();
    chk("mrst_x", {31'd0, x}, 0);
    chk("mrst_xv", {31'd0, x_valid}, 0);
    chk("mrst_busy", {31'd0, busy}, 0);
    xv0 = xv_count;
    repeat (20) step();
    chk("mrst_no_resume", xv_count - xv0, 0);
    chk("mrst_busy2", {31'd0, busy}, 0);

    // random words with random gaps
    for (int i = 0; i < 8; i++) begin
      send(W'($urandom));
      din_valid = 1'b0;
      repeat ($urandom_range(0, 10)) step();
    end
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=0", 1);
    $fatal(1, "timeout");
  end

endmodule
